// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: sram-like instruction bus plus the DE-side control and IF/DE register outputs.
// The master side is the fetch stage; the slave side is the memory/pipeline environment.
interface fetch_stage_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        DE_PcSelecter;
  logic [31:0] DE_Target;
  logic        DE_Stall;
  logic        EXC_Redirect;
  logic [31:0] EXC_Target;

  logic [31:0] DE_Inst;
  logic [31:0] DE_Pc;
  logic        DE_Valid;
  logic        DE_AdEL;

  modport master (
    output inst_req, inst_addr, DE_Inst, DE_Pc, DE_Valid, DE_AdEL,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
           DE_PcSelecter, DE_Target, DE_Stall, EXC_Redirect, EXC_Target
  );

  modport slave (
    input  inst_req, inst_addr, DE_Inst, DE_Pc, DE_Valid, DE_AdEL,
    output inst_addr_ok, inst_data_ok, inst_rdata,
           DE_PcSelecter, DE_Target, DE_Stall, EXC_Redirect, EXC_Target
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage: one outstanding sram-like read, IF/DE register, delay-slot
// aware branch redirect and exception redirect with cancellation of the in-flight read.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic               clk,
  input  logic               rst,
  fetch_stage_if.master      fif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL, S_HALT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_fpc;
  logic [31:0] r_buf;
  logic [31:0] r_ptgt;
  logic        r_pend;
  logic        r_cancel;
  logic [31:0] r_de_inst;
  logic [31:0] r_de_pc;
  logic        r_de_valid;
  logic        r_de_adel;

  logic        w_misaligned;
  logic        w_accept;
  logic        w_branch;
  logic [31:0] w_slot;
  logic [31:0] w_seq_pc;

  assign w_misaligned = |r_pc[1:0];
  assign w_accept     = (r_state == S_REQ) && !w_misaligned && fif.inst_addr_ok;
  assign w_branch     = fif.DE_PcSelecter && r_de_valid && !fif.DE_Stall;
  assign w_slot       = r_de_pc + 32'd4;
  assign w_seq_pc     = r_pend ? r_ptgt : (r_pc + 32'd4);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_fpc      <= 32'd0;
      r_buf      <= 32'd0;
      r_ptgt     <= 32'd0;
      r_pend     <= 1'b0;
      r_cancel   <= 1'b0;
      r_de_inst  <= 32'd0;
      r_de_pc    <= 32'd0;
      r_de_valid <= 1'b0;
      r_de_adel  <= 1'b0;
    end else if (fif.EXC_Redirect) begin
      r_pc       <= fif.EXC_Target;
      r_pend     <= 1'b0;
      r_de_inst  <= 32'd0;
      r_de_pc    <= 32'd0;
      r_de_valid <= 1'b0;
      r_de_adel  <= 1'b0;
      case (r_state)
        S_REQ: begin
          // A request accepted in the redirect cycle still returns data; mark it for dropping.
          if (w_accept) begin
            r_fpc    <= r_pc;
            r_cancel <= 1'b1;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fif.inst_data_ok) begin
            r_cancel <= 1'b0;
            r_state  <= S_REQ;
          end else begin
            r_cancel <= 1'b1;
          end
        end
        default: begin
          r_cancel <= 1'b0;
          r_state  <= S_REQ;
        end
      endcase
    end else begin
      if (w_accept) begin
        r_fpc  <= r_pc;
        r_pend <= 1'b0;
        r_pc   <= w_branch ? fif.DE_Target : w_seq_pc;
      end else if (w_branch) begin
        // Delay slot not yet requested: let it go out first, then jump.
        if (r_pc == w_slot) begin
          r_pend <= 1'b1;
          r_ptgt <= fif.DE_Target;
        end else begin
          r_pc <= fif.DE_Target;
        end
      end

      if (!fif.DE_Stall) begin
        r_de_inst  <= 32'd0;
        r_de_pc    <= 32'd0;
        r_de_valid <= 1'b0;
        r_de_adel  <= 1'b0;
      end

      case (r_state)
        S_REQ: begin
          if (w_misaligned) begin
            if (!fif.DE_Stall) begin
              r_de_inst  <= 32'd0;
              r_de_pc    <= r_pc;
              r_de_valid <= 1'b1;
              r_de_adel  <= 1'b1;
              r_state    <= S_HALT;
            end
          end else if (w_accept) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fif.inst_data_ok) begin
            if (r_cancel) begin
              r_cancel <= 1'b0;
              r_state  <= S_REQ;
            end else if (fif.DE_Stall) begin
              r_buf   <= fif.inst_rdata;
              r_state <= S_FULL;
            end else begin
              r_de_inst  <= fif.inst_rdata;
              r_de_pc    <= r_fpc;
              r_de_valid <= 1'b1;
              r_de_adel  <= 1'b0;
              r_state    <= S_REQ;
            end
          end
        end
        S_FULL: begin
          if (!fif.DE_Stall) begin
            r_de_inst  <= r_buf;
            r_de_pc    <= r_fpc;
            r_de_valid <= 1'b1;
            r_de_adel  <= 1'b0;
            r_state    <= S_REQ;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign fif.inst_req  = (r_state == S_REQ) && !w_misaligned && !rst;
  assign fif.inst_addr = r_pc;
  assign fif.DE_Inst   = r_de_inst;
  assign fif.DE_Pc     = r_de_pc;
  assign fif.DE_Valid  = r_de_valid;
  assign fif.DE_AdEL   = r_de_adel;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected request addresses and
// DE entries; a memory/monitor process and a DE monitor pop and compare independently.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_if fif();

  fetch_stage #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adel;
  } de_t;

  int checks = 0;
  int errors = 0;
  de_t         de_q[$];
  logic [31:0] req_q[$];

  int mem_budget = 0;
  int mem_delay  = 0;
  bit mem_accept = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic push_pair(input logic [31:0] addr);
    req_q.push_back(addr);
    de_q.push_back('{addr, addr, 1'b0});
  endtask

  task automatic push_seq(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) push_pair(first + 32'(4 * i));
  endtask

  // Memory model + request monitor: decisions made just after the falling edge.
  initial begin
    bit          p_valid = 1'b0;
    logic [31:0] p_addr = 32'd0;
    int          p_cnt = 0;
    bit          l_req = 1'b0, l_aok = 1'b0, l_dok = 1'b0;
    logic [31:0] l_addr = 32'd0;
    logic [31:0] exp_addr;
    fif.inst_addr_ok = 1'b0;
    fif.inst_data_ok = 1'b0;
    fif.inst_rdata   = 32'd0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        p_valid = 1'b0;
        l_req = 1'b0; l_aok = 1'b0; l_dok = 1'b0;
        fif.inst_addr_ok = 1'b0;
        fif.inst_data_ok = 1'b0;
      end else begin
        if (l_dok) p_valid = 1'b0;
        if (l_req && l_aok) begin
          checks++;
          if (req_q.size() == 0) begin
            errors++;
            $display("FAIL req_order got=%h expected=none", l_addr);
          end else begin
            exp_addr = req_q.pop_front();
            if (l_addr !== exp_addr) begin
              errors++;
              $display("FAIL req_order got=%h expected=%h", l_addr, exp_addr);
            end
          end
          p_valid = 1'b1;
          p_addr  = l_addr;
          p_cnt   = mem_delay;
          mem_budget--;
        end else if (p_valid && p_cnt > 0) begin
          p_cnt--;
        end
        fif.inst_addr_ok = mem_accept && fif.inst_req && (mem_budget > 0);
        fif.inst_data_ok = p_valid && (p_cnt == 0);
        fif.inst_rdata   = p_addr;
        l_req  = fif.inst_req;
        l_addr = fif.inst_addr;
        l_aok  = fif.inst_addr_ok;
        l_dok  = fif.inst_data_ok;
      end
    end
  end

  // DE monitor: a fresh entry exists whenever DE was allowed to update and now holds a valid one.
  initial begin
    logic s, r;
    de_t  e;
    forever begin
      @(posedge clk);
      s = fif.DE_Stall;
      r = rst;
      #1;
      if (!r && !s && fif.DE_Valid) begin
        checks++;
        if (de_q.size() == 0) begin
          errors++;
          $display("FAIL de_entry got inst=%h pc=%h adel=%b expected=none",
                   fif.DE_Inst, fif.DE_Pc, fif.DE_AdEL);
        end else begin
          e = de_q.pop_front();
          if (fif.DE_Inst !== e.inst || fif.DE_Pc !== e.pc || fif.DE_AdEL !== e.adel) begin
            errors++;
            $display("FAIL de_entry got inst=%h pc=%h adel=%b expected inst=%h pc=%h adel=%b",
                     fif.DE_Inst, fif.DE_Pc, fif.DE_AdEL, e.inst, e.pc, e.adel);
          end
        end
      end
    end
  end

  task automatic do_reset(input int budget, input int delay);
    @(negedge clk);
    rst = 1'b1;
    fif.DE_PcSelecter = 1'b0;
    fif.DE_Target     = 32'd0;
    fif.DE_Stall      = 1'b0;
    fif.EXC_Redirect  = 1'b0;
    fif.EXC_Target    = 32'd0;
    mem_accept = 1'b1;
    mem_delay  = delay;
    repeat (2) @(negedge clk);
    mem_budget = budget;
  endtask

  task automatic release_reset();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_de(input logic [31:0] pc);
    int n = 0;
    while (!(fif.DE_Valid && fif.DE_Pc == pc) && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (n >= 80) begin
      checks++;
      errors++;
      $display("FAIL wait_de timeout got=%h expected=%h", fif.DE_Pc, pc);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((req_q.size() != 0 || de_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    chk("req_q_left", req_q.size(), 0);
    chk("de_q_left", de_q.size(), 0);
    req_q.delete();
    de_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Sequential fetch with zero-wait memory.
    do_reset(4, 0);
    chk("rst_inst_req", fif.inst_req, 0);
    chk("rst_de_valid", fif.DE_Valid, 0);
    chk("rst_de_inst", fif.DE_Inst, 0);
    chk("rst_de_pc", fif.DE_Pc, 0);
    chk("rst_de_adel", fif.DE_AdEL, 0);
    push_seq(32'hBFC0_0000, 4);
    release_reset();
    chk("first_inst_req", fif.inst_req, 1);
    chk("first_inst_addr", fif.inst_addr, 32'hBFC0_0000);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("seq_de_valid", fif.DE_Valid, ((k % 2) == 0) ? 32'd1 : 32'd0);
    end
    drain();

    // DE stalled while data returns: buffered, no new request, delivered on release.
    do_reset(3, 0);
    push_seq(32'hBFC0_0000, 3);
    release_reset();
    repeat (3) @(negedge clk);
    fif.DE_Stall = 1'b1;
    @(negedge clk);
    chk("full_no_req", fif.inst_req, 0);
    chk("full_de_held", fif.DE_Valid, 0);
    @(negedge clk);
    chk("full_no_req2", fif.inst_req, 0);
    @(negedge clk);
    fif.DE_Stall = 1'b0;
    drain();

    // Branch at BFC00010, delay slot not yet requested.
    do_reset(8, 0);
    push_seq(32'hBFC0_0000, 6);
    push_seq(32'hBFC0_0100, 2);
    release_reset();
    wait_de(32'hBFC0_0010);
    fif.DE_PcSelecter = 1'b1;
    fif.DE_Target     = 32'hBFC0_0100;
    mem_accept        = 1'b0;
    @(negedge clk);
    fif.DE_PcSelecter = 1'b0;
    mem_accept        = 1'b1;
    drain();

    // Branch at BFC00010 held in DE while its delay slot is fetched and buffered.
    do_reset(8, 0);
    push_seq(32'hBFC0_0000, 6);
    push_seq(32'hBFC0_0100, 2);
    release_reset();
    wait_de(32'hBFC0_0010);
    fif.DE_Stall      = 1'b1;
    fif.DE_PcSelecter = 1'b1;
    fif.DE_Target     = 32'hBFC0_0100;
    repeat (3) @(negedge clk);
    fif.DE_Stall = 1'b0;
    @(negedge clk);
    fif.DE_PcSelecter = 1'b0;
    drain();

    // Exception redirect while waiting for data that arrives two cycles later.
    do_reset(3, 2);
    req_q.push_back(32'hBFC0_0000);
    push_pair(32'hBFC0_0380);
    push_pair(32'hBFC0_0384);
    release_reset();
    @(negedge clk);
    fif.EXC_Redirect = 1'b1;
    fif.EXC_Target   = 32'hBFC0_0380;
    @(negedge clk);
    fif.EXC_Redirect = 1'b0;
    @(negedge clk);
    chk("exc_de_bubble", fif.DE_Valid, 0);
    @(negedge clk);
    chk("exc_drop_bubble", fif.DE_Valid, 0);
    chk("exc_req", fif.inst_req, 1);
    chk("exc_addr", fif.inst_addr, 32'hBFC0_0380);
    drain();

    // Misaligned branch target: AdEL entry, halt, resume on exception redirect.
    do_reset(8, 0);
    push_seq(32'hBFC0_0000, 6);
    de_q.push_back('{32'd0, 32'hBFC0_0102, 1'b1});
    push_pair(32'hBFC0_0200);
    push_pair(32'hBFC0_0204);
    release_reset();
    wait_de(32'hBFC0_0010);
    fif.DE_PcSelecter = 1'b1;
    fif.DE_Target     = 32'hBFC0_0102;
    @(negedge clk);
    fif.DE_PcSelecter = 1'b0;
    wait_de(32'hBFC0_0102);
    chk("adel_flag", fif.DE_AdEL, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("halt_no_req", fif.inst_req, 0);
    end
    fif.EXC_Redirect = 1'b1;
    fif.EXC_Target   = 32'hBFC0_0200;
    @(negedge clk);
    fif.EXC_Redirect = 1'b0;
    drain();

    // Exception and branch redirect together: exception wins, pending branch discarded.
    do_reset(7, 0);
    push_seq(32'hBFC0_0000, 5);
    push_pair(32'hBFC0_0380);
    push_pair(32'hBFC0_0384);
    release_reset();
    wait_de(32'hBFC0_0010);
    fif.DE_PcSelecter = 1'b1;
    fif.DE_Target     = 32'hBFC0_0100;
    fif.EXC_Redirect  = 1'b1;
    fif.EXC_Target    = 32'hBFC0_0380;
    mem_accept        = 1'b0;
    @(negedge clk);
    fif.DE_PcSelecter = 1'b0;
    fif.EXC_Redirect  = 1'b0;
    mem_accept        = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
